// File: rtl/depthwise_frame_scheduler.sv
// Frame sequencer for the depthwise 3x3 convolution bank: loads one frame, injects zero
// flush pixels to drain the line buffers, then forwards and counts the bank's outputs.
module depthwise_frame_scheduler #(
    parameter int  DATA_WIDHT   = 32,
    parameter int  NUM_CHANNEL  = 16,
    parameter int  IMG_WIDHT    = 44,
    parameter int  IMG_HEIGHT   = 44,
    parameter int  FLUSH_PIXELS = IMG_WIDHT + 1,
    parameter int  TIMEOUT      = 4 * IMG_WIDHT,
    localparam int PIX_W        = DATA_WIDHT * NUM_CHANNEL,
    localparam int CNT_W        = $clog2(IMG_WIDHT * IMG_HEIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [PIX_W-1:0] conv_data_in,
    output logic             conv_valid_in,
    input  logic [PIX_W-1:0] conv_data_out,
    input  logic             conv_valid_out,
    output logic [PIX_W-1:0] m_data,
    output logic             m_valid,
    output logic [CNT_W-1:0] in_cnt,
    output logic [CNT_W-1:0] out_cnt
);

    localparam int N       = IMG_WIDHT * IMG_HEIGHT;
    localparam int FLUSH_W = $clog2(FLUSH_PIXELS + 1);
    localparam int IDLE_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]   N_C          = CNT_W'(N);
    localparam logic [CNT_W-1:0]   LAST_PIX_C   = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
    localparam logic [FLUSH_W-1:0] LAST_FLUSH_C = FLUSH_W'(FLUSH_PIXELS - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_ONE    = FLUSH_W'(1);
    localparam logic [IDLE_W-1:0]  TIMEOUT_C    = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0]  IDLE_ONE     = IDLE_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic               s_ready_r;
    logic [PIX_W-1:0]   conv_data_in_r;
    logic               conv_valid_in_r;
    logic [CNT_W-1:0]   in_cnt_r;
    logic [CNT_W-1:0]   out_cnt_r;
    logic [FLUSH_W-1:0] flush_cnt_r;
    logic [IDLE_W-1:0]  idle_cnt_r;

    logic               accept_s;
    logic               m_valid_s;
    logic               overflow_s;
    logic               out_full_s;

    // s_ready_r is only ever high in LOAD, so it alone qualifies an upstream beat.
    assign accept_s   = s_valid & s_ready_r;
    assign out_full_s = (out_cnt_r == N_C);
    assign m_valid_s  = conv_valid_out & busy_r & (out_cnt_r < N_C);
    // Any bank output that cannot be forwarded is an overflow: outside a frame or past N.
    assign overflow_s = conv_valid_out & ~m_valid_s;

    // Frame sequencing: state, registered handshake/status outputs and all counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            err_r           <= 1'b0;
            s_ready_r       <= 1'b0;
            conv_data_in_r  <= '0;
            conv_valid_in_r <= 1'b0;
            in_cnt_r        <= '0;
            out_cnt_r       <= '0;
            flush_cnt_r     <= '0;
            idle_cnt_r      <= '0;
        end else begin
            if (m_valid_s) begin
                out_cnt_r <= out_cnt_r + CNT_ONE;
            end
            if (overflow_s) begin
                err_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    done_r          <= 1'b0;
                    conv_valid_in_r <= 1'b0;
                    s_ready_r       <= 1'b0;
                    busy_r          <= 1'b0;
                    if (start) begin
                        in_cnt_r    <= '0;
                        out_cnt_r   <= '0;
                        err_r       <= 1'b0;
                        flush_cnt_r <= '0;
                        idle_cnt_r  <= '0;
                        s_ready_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    conv_valid_in_r <= accept_s;
                    if (accept_s) begin
                        conv_data_in_r <= s_data;
                        in_cnt_r       <= in_cnt_r + CNT_ONE;
                        if (in_cnt_r == LAST_PIX_C) begin
                            s_ready_r <= 1'b0;
                            state_r   <= ST_FLUSH;
                        end
                    end
                end

                ST_FLUSH: begin
                    conv_data_in_r  <= '0;
                    conv_valid_in_r <= 1'b1;
                    flush_cnt_r     <= flush_cnt_r + FLUSH_ONE;
                    if (flush_cnt_r == LAST_FLUSH_C) begin
                        state_r <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    conv_valid_in_r <= 1'b0;
                    // Completion takes priority over a timeout reached on the same cycle.
                    if (out_full_s) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (idle_cnt_r == TIMEOUT_C) begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (conv_valid_out) begin
                        idle_cnt_r <= '0;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + IDLE_ONE;
                    end
                end

                ST_DONE: begin
                    done_r          <= 1'b0;
                    conv_valid_in_r <= 1'b0;
                    state_r         <= ST_IDLE;
                end

                default: begin
                    state_r         <= ST_IDLE;
                    busy_r          <= 1'b0;
                    done_r          <= 1'b0;
                    s_ready_r       <= 1'b0;
                    conv_valid_in_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign s_ready       = s_ready_r;
    assign conv_data_in  = conv_data_in_r;
    assign conv_valid_in = conv_valid_in_r;
    assign in_cnt        = in_cnt_r;
    assign out_cnt       = out_cnt_r;
    assign m_data        = conv_data_out;
    assign m_valid       = m_valid_s;

endmodule

// File: tb/tb_depthwise_frame_scheduler.sv
// Randomized self-checking bench for depthwise_frame_scheduler on a 4x4 frame, with a
// behavioural bank that emits one output per input once its line buffers have filled.
module tb_depthwise_frame_scheduler;

    localparam int DW  = 32;
    localparam int NC  = 16;
    localparam int W   = 4;
    localparam int H   = 4;
    localparam int N   = W * H;
    localparam int FL  = W + 1;
    localparam int TO  = 4 * W;
    localparam int PW  = DW * NC;
    localparam int CW  = $clog2(N + 1);
    localparam int LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [PW-1:0] s_data = '0;
    logic [PW-1:0] conv_data_out = '0;
    logic          conv_valid_out = 1'b0;
    logic          busy, done, err, s_ready, conv_valid_in, m_valid;
    logic [PW-1:0] conv_data_in, m_data;
    logic [CW-1:0] in_cnt, out_cnt;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int frame_id = 0;

    // Driver-side record of each frame
    logic [PW-1:0] sent_q[$];
    int            acc_q[$];
    int            bank_limit = N;
    int            bank_extra = 0;

    // Monitor-side record of each frame
    logic [PW-1:0] cin_q[$];
    int            cin_cyc_q[$];
    logic [PW-1:0] mout_q[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            last_out_cyc = 0;
    int            mon_frame = 0;

    // Bank model state
    logic [PW-1:0] bank_q[$];
    int            bank_in = 0;
    int            bank_out = 0;
    int            bank_extra_used = 0;
    int            bank_frame = 0;
    bit            emit;

    depthwise_frame_scheduler #(
        .DATA_WIDHT (DW),
        .NUM_CHANNEL(NC),
        .IMG_WIDHT  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .conv_data_in  (conv_data_in),
        .conv_valid_in (conv_valid_in),
        .conv_data_out (conv_data_out),
        .conv_valid_out(conv_valid_out),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .in_cnt        (in_cnt),
        .out_cnt       (out_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] rand_pix();
        logic [PW-1:0] p;
        for (int c = 0; c < NC; c++) p[c*DW +: DW] = $urandom();
        p[0] = 1'b1;
        return p;
    endfunction

    // Bank: output k appears with input k+LAT; optional spurious outputs after the stream.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            conv_valid_out = 1'b0;
            conv_data_out  = '0;
            bank_in = 0;
            bank_out = 0;
            bank_extra_used = 0;
        end else begin
            #1;
            if (bank_frame != frame_id) begin
                bank_frame = frame_id;
                bank_in = 0;
                bank_out = 0;
                bank_extra_used = 0;
                bank_q.delete();
            end
            emit = 1'b0;
            if (conv_valid_in === 1'b1) begin
                bank_in++;
                emit = (bank_in > LAT) && (bank_out < bank_limit);
            end else if (bank_in == N + FL && bank_extra_used < bank_extra) begin
                emit = 1'b1;
                bank_extra_used++;
            end
            if (emit) begin
                conv_data_out  = rand_pix();
                conv_valid_out = 1'b1;
                bank_out++;
                bank_q.push_back(conv_data_out);
            end else begin
                conv_valid_out = 1'b0;
                conv_data_out  = '0;
            end
        end
    end

    // Monitor: records bank-side beats, forwarded outputs and done pulses per frame.
    always @(negedge clk) begin
        if (mon_frame != frame_id) begin
            cin_q.delete();
            cin_cyc_q.delete();
            mout_q.delete();
            done_cnt = 0;
            done_cyc = 0;
            last_out_cyc = 0;
            mon_frame = frame_id;
        end
        if (conv_valid_in === 1'b1) begin
            cin_q.push_back(conv_data_in);
            cin_cyc_q.push_back(cyc);
        end
        if (m_valid === 1'b1) mout_q.push_back(m_data);
        if (conv_valid_out === 1'b1) last_out_cyc = cyc;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // Expected bank-side stream: the N accepted pixels in order, then FL zero pixels.
    function automatic int stream_errs();
        int e = 0;
        if (cin_q.size() != N + FL) e++;
        for (int i = 0; i < cin_q.size(); i++) begin
            logic [PW-1:0] exp_v;
            exp_v = (i < N && i < sent_q.size()) ? sent_q[i] : '0;
            if (cin_q[i] !== exp_v) e++;
        end
        return e;
    endfunction

    // Expected forwarded outputs: the first min(emitted, N) bank outputs.
    function automatic int fwd_errs();
        int e = 0;
        int exp_n = (bank_q.size() < N) ? bank_q.size() : N;
        if (mout_q.size() != exp_n) e++;
        for (int i = 0; i < mout_q.size(); i++) begin
            if (i >= exp_n || mout_q[i] !== bank_q[i]) e++;
        end
        return e;
    endfunction

    // Each accepted beat must show on conv_valid_in in the cycle right after acceptance.
    function automatic int sync_errs();
        int e = 0;
        if (acc_q.size() != N || cin_cyc_q.size() < N) e++;
        for (int i = 0; i < acc_q.size() && i < cin_cyc_q.size(); i++) begin
            if (cin_cyc_q[i] != acc_q[i]) e++;
        end
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic new_frame(input int limit, input int extra);
        frame_id++;
        bank_limit = limit;
        bank_extra = extra;
        sent_q.delete();
        acc_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: back-to-back, 1: valid toggling 1,0,1,0, 2: random gaps
    task automatic send_pixels(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            int gap;
            int guard;
            logic [PW-1:0] p;
            if (mode == 1 && i > 0) gap = 1;
            else if (mode == 2) gap = int'($urandom_range(0, 3));
            else gap = 0;
            if (gap > 0) begin
                s_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            p = rand_pix();
            s_valid = 1'b1;
            s_data = p;
            guard = 0;
            while (s_ready !== 1'b1 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (s_ready === 1'b1) begin
                sent_q.push_back(p);
                acc_q.push_back(cyc + 1);
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int c = 0;
        while (done_cnt == 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        tests++;
        if (done_cnt == 0) begin
            fails++;
            $display("FAIL %s: no done pulse within %0d cycles", tag, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        tests++;
        if ({busy, done, err, s_ready, conv_valid_in, m_valid} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy, done, err, s_ready, conv_valid_in, m_valid});
        end
        do_reset();
        tests++;
        if (conv_data_in !== '0 || in_cnt !== '0 || out_cnt !== '0) begin
            fails++;
            $display("FAIL reset_data: conv_data_in_nonzero=%0d in_cnt=%0d out_cnt=%0d expected 0 0 0",
                     conv_data_in != '0, in_cnt, out_cnt);
        end
        tests++;
        if ({busy, done, err, s_ready, conv_valid_in} !== 5'b0) begin
            fails++;
            $display("FAIL reset_release: got %b expected 00000", {busy, done, err, s_ready, conv_valid_in});
        end
    endtask

    task automatic test_back_to_back();
        new_frame(N, 0);
        pulse_start();
        tests++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_load_entry: busy=%b s_ready=%b expected 1 1", busy, s_ready);
        end
        send_pixels(N, 0);
        tests++;
        if (s_ready !== 1'b0 || in_cnt !== CW'(N)) begin
            fails++;
            $display("FAIL b2b_after_last: s_ready=%b in_cnt=%0d expected 0 %0d", s_ready, in_cnt, N);
        end
        wait_done(300, "b2b_done");
        tests++;
        if (stream_errs() != 0) begin
            fails++;
            $display("FAIL b2b_stream: %0d mismatches over %0d beats, expected 0 over %0d",
                     stream_errs(), cin_q.size(), N + FL);
        end
        tests++;
        if (cin_cyc_q.size() == 0 || cin_cyc_q[cin_cyc_q.size()-1] - cin_cyc_q[0] != N + FL - 1) begin
            fails++;
            $display("FAIL b2b_contiguous: beats=%0d expected %0d consecutive cycles",
                     cin_cyc_q.size(), N + FL);
        end
        tests++;
        if (fwd_errs() != 0 || out_cnt !== CW'(N)) begin
            fails++;
            $display("FAIL b2b_forward: errs=%0d out_cnt=%0d expected 0 %0d", fwd_errs(), out_cnt, N);
        end
        tests++;
        if (done_cnt != 1 || err !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: done_cnt=%0d err=%b busy=%b expected 1 0 0", done_cnt, err, busy);
        end
    endtask

    task automatic test_toggle_valid();
        new_frame(N, 0);
        pulse_start();
        send_pixels(N, 1);
        tests++;
        if (s_ready !== 1'b0 || in_cnt !== CW'(N)) begin
            fails++;
            $display("FAIL toggle_after_last: s_ready=%b in_cnt=%0d expected 0 %0d", s_ready, in_cnt, N);
        end
        wait_done(300, "toggle_done");
        tests++;
        if (sync_errs() != 0) begin
            fails++;
            $display("FAIL toggle_latency: %0d beats off their acceptance cycle, expected 0", sync_errs());
        end
        tests++;
        if (stream_errs() != 0 || done_cnt != 1 || err !== 1'b0) begin
            fails++;
            $display("FAIL toggle_frame: stream_errs=%0d done_cnt=%0d err=%b expected 0 1 0",
                     stream_errs(), done_cnt, err);
        end
    endtask

    task automatic test_timeout();
        int gap;
        new_frame(N - 1, 0);
        pulse_start();
        send_pixels(N, 0);
        wait_done(300, "timeout_done");
        gap = done_cyc - last_out_cyc - 1;
        tests++;
        if (gap < TO || gap > TO + 2) begin
            fails++;
            $display("FAIL timeout_idle: %0d idle cycles before done, expected %0d..%0d", gap, TO, TO + 2);
        end
        tests++;
        if (err !== 1'b1 || done_cnt != 1 || out_cnt !== CW'(N - 1) || fwd_errs() != 0) begin
            fails++;
            $display("FAIL timeout_end: err=%b done_cnt=%0d out_cnt=%0d fwd_errs=%0d expected 1 1 %0d 0",
                     err, done_cnt, out_cnt, fwd_errs(), N - 1);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_sticky: err=%b expected 1", err);
        end
    endtask

    task automatic test_overflow();
        new_frame(N, 1);
        pulse_start();
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL overflow_start_clears: err=%b expected 0", err);
        end
        send_pixels(N, 0);
        wait_done(300, "overflow_done");
        tests++;
        if (bank_q.size() != N + 1 || mout_q.size() != N || fwd_errs() != 0) begin
            fails++;
            $display("FAIL overflow_forward: emitted=%0d forwarded=%0d errs=%0d expected %0d %0d 0",
                     bank_q.size(), mout_q.size(), fwd_errs(), N + 1, N);
        end
        tests++;
        if (err !== 1'b1 || out_cnt !== CW'(N) || done_cnt != 1) begin
            fails++;
            $display("FAIL overflow_end: err=%b out_cnt=%0d done_cnt=%0d expected 1 %0d 1",
                     err, out_cnt, done_cnt, N);
        end
    endtask

    task automatic test_reset_mid_frame();
        new_frame(N, 0);
        pulse_start();
        send_pixels(7, 0);
        tests++;
        if (in_cnt !== CW'(7) || busy !== 1'b1) begin
            fails++;
            $display("FAIL midrst_pre: in_cnt=%0d busy=%b expected 7 1", in_cnt, busy);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if ({busy, done, err, s_ready, conv_valid_in, m_valid} !== 6'b0 ||
            conv_data_in !== '0 || in_cnt !== '0 || out_cnt !== '0) begin
            fails++;
            $display("FAIL midrst_outputs: flags=%b in_cnt=%0d out_cnt=%0d expected 000000 0 0",
                     {busy, done, err, s_ready, conv_valid_in, m_valid}, in_cnt, out_cnt);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        tests++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midrst_no_done: done_cnt=%0d busy=%b expected 0 0", done_cnt, busy);
        end
        new_frame(N, 0);
        pulse_start();
        send_pixels(N, 0);
        wait_done(300, "midrst_clean_done");
        tests++;
        if (stream_errs() != 0 || fwd_errs() != 0 || done_cnt != 1 || err !== 1'b0 || out_cnt !== CW'(N)) begin
            fails++;
            $display("FAIL midrst_clean_frame: stream=%0d fwd=%0d done_cnt=%0d err=%b out_cnt=%0d expected 0 0 1 0 %0d",
                     stream_errs(), fwd_errs(), done_cnt, err, out_cnt, N);
        end
    endtask

    task automatic test_start_in_flush();
        new_frame(N, 0);
        pulse_start();
        send_pixels(N, 0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(300, "flushstart_done");
        repeat (30) @(negedge clk);
        tests++;
        if (done_cnt != 1 || busy !== 1'b0 || stream_errs() != 0) begin
            fails++;
            $display("FAIL flushstart_ignored: done_cnt=%0d busy=%b stream_errs=%0d expected 1 0 0",
                     done_cnt, busy, stream_errs());
        end
    endtask

    task automatic test_random_gaps();
        for (int f = 0; f < 3; f++) begin
            new_frame(N, 0);
            pulse_start();
            send_pixels(N, 2);
            wait_done(400, "rand_done");
            tests++;
            if (sync_errs() != 0 || stream_errs() != 0 || fwd_errs() != 0) begin
                fails++;
                $display("FAIL rand_frame%0d: sync=%0d stream=%0d fwd=%0d expected 0 0 0",
                         f, sync_errs(), stream_errs(), fwd_errs());
            end
            tests++;
            if (done_cnt != 1 || err !== 1'b0 || in_cnt !== CW'(N) || out_cnt !== CW'(N)) begin
                fails++;
                $display("FAIL rand_end%0d: done_cnt=%0d err=%b in_cnt=%0d out_cnt=%0d expected 1 0 %0d %0d",
                         f, done_cnt, err, in_cnt, out_cnt, N, N);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_toggle_valid();
        test_timeout();
        test_overflow();
        test_reset_mid_frame();
        test_start_in_flush();
        test_random_gaps();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
